// File: rtl/lock_code_entry.sv
// Keypad combination lock: debounces the encoded switch digit, collects
// digit sequences, checks them against a programmable code and drives lock/alarm status.
module lock_code_entry #(
  parameter int unsigned              CODE_LEN   = 4,
  parameter int unsigned              DEBOUNCE   = 16,
  parameter int unsigned              MAX_TRIES  = 3,
  parameter logic [CODE_LEN*4-1:0]    RESET_CODE = 16'h1234
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] num,
  input  logic       lock_cmd,
  input  logic       prog,
  output logic       unlocked,
  output logic       alarm,
  output logic [3:0] entered,
  output logic [3:0] disp
);

  localparam int unsigned CW = CODE_LEN * 4;
  localparam int unsigned RW = $clog2(DEBOUNCE + 1);
  localparam int unsigned FW = $clog2(MAX_TRIES + 1);
  localparam logic [RW-1:0] DB_MAX = RW'(DEBOUNCE);
  localparam logic [3:0]    LEN4   = 4'(CODE_LEN);
  localparam logic [FW-1:0] FMAX   = FW'(MAX_TRIES);

  typedef enum logic [2:0] {
    ST_LOCKED,
    ST_CHECK,
    ST_OPEN,
    ST_PROGRAM,
    ST_ALARM
  } state_t;

  // ---------------- debouncer ----------------
  logic [3:0]    digit;
  logic [3:0]    last_q;
  logic [RW-1:0] run_q, run_d;
  logic          armed_q, armed_d;
  logic          press_q, press_d;
  logic [3:0]    pdig_q;

  assign digit = (num > 4'd9) ? 4'd0 : num;

  // run counts consecutive identical samples, saturating at DEBOUNCE
  always_comb begin
    run_d = RW'(1);
    if (digit == last_q) begin
      run_d = (run_q == DB_MAX) ? run_q : run_q + RW'(1);
    end
    press_d = armed_q && (digit != 4'd0) && (run_d == DB_MAX);
    armed_d = armed_q;
    if (press_d) begin
      armed_d = 1'b0;
    end else if ((digit == 4'd0) && (run_d == DB_MAX)) begin
      armed_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q  <= 4'd0;
      run_q   <= '0;
      armed_q <= 1'b0;
      press_q <= 1'b0;
      pdig_q  <= 4'd0;
    end else begin
      last_q  <= digit;
      run_q   <= run_d;
      armed_q <= armed_d;
      press_q <= press_d;
      pdig_q  <= digit;
    end
  end

  // ---------------- entry / check FSM ----------------
  state_t        state_q, state_d;
  logic [CW-1:0] entry_q, entry_d;
  logic [CW-1:0] code_q, code_d;
  logic [3:0]    entered_q, entered_d;
  logic [FW-1:0] fails_q, fails_d;
  logic [CW-1:0] shifted;

  assign shifted = {entry_q[CW-5:0], pdig_q};

  always_comb begin
    state_d   = state_q;
    entry_d   = entry_q;
    code_d    = code_q;
    entered_d = entered_q;
    fails_d   = fails_q;
    case (state_q)
      ST_LOCKED: begin
        if (lock_cmd) begin
          entry_d   = '0;
          entered_d = 4'd0;
        end else if (press_q) begin
          entry_d   = shifted;
          entered_d = entered_q + 4'd1;
          if (entered_q + 4'd1 == LEN4) state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        entry_d   = '0;
        entered_d = 4'd0;
        if (entry_q == code_q) begin
          fails_d = '0;
          state_d = ST_OPEN;
        end else begin
          fails_d = (fails_q == FMAX) ? fails_q : fails_q + FW'(1);
          state_d = (fails_d == FMAX) ? ST_ALARM : ST_LOCKED;
        end
      end
      ST_OPEN: begin
        if (lock_cmd) begin
          state_d = ST_LOCKED;
        end else if (press_q && prog) begin
          entry_d   = {{(CW-4){1'b0}}, pdig_q};
          entered_d = 4'd1;
          state_d   = ST_PROGRAM;
        end
      end
      ST_PROGRAM: begin
        if (lock_cmd) begin
          entry_d   = '0;
          entered_d = 4'd0;
          state_d   = ST_LOCKED;
        end else if (press_q) begin
          entry_d   = shifted;
          entered_d = entered_q + 4'd1;
          if (entered_q + 4'd1 == LEN4) begin
            code_d    = shifted;
            entry_d   = '0;
            entered_d = 4'd0;
            state_d   = ST_OPEN;
          end
        end
      end
      ST_ALARM: ;
      default: begin
        entry_d   = '0;
        entered_d = 4'd0;
        state_d   = ST_LOCKED;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_LOCKED;
      entry_q   <= '0;
      code_q    <= RESET_CODE;
      entered_q <= 4'd0;
      fails_q   <= '0;
    end else begin
      state_q   <= state_d;
      entry_q   <= entry_d;
      code_q    <= code_d;
      entered_q <= entered_d;
      fails_q   <= fails_d;
    end
  end

  assign unlocked = (state_q == ST_OPEN) || (state_q == ST_PROGRAM);
  assign alarm    = (state_q == ST_ALARM);
  assign entered  = entered_q;

  always_comb begin
    disp = 4'hC;
    case (state_q)
      ST_OPEN:    disp = 4'h0;
      ST_PROGRAM: disp = 4'hF;
      ST_ALARM:   disp = 4'hE;
      default:    disp = (entered_q != 4'd0) ? entry_q[3:0] : 4'hC;
    endcase
  end

endmodule

// File: tb/tb_lock_code_entry.sv
// Bench for lock_code_entry: directed scenarios plus random key traffic,
// every cycle compared against a queue-based behavioural model.
module tb_lock_code_entry;

  localparam int LEN  = 4;
  localparam int DB   = 4;
  localparam int MAXT = 3;
  localparam logic [15:0] RCODE = 16'h1234;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] num = 4'd0;
  logic       lock_cmd = 1'b0;
  logic       prog = 1'b0;
  logic       unlocked, alarm;
  logic [3:0] entered, disp;

  always #5 clk = ~clk;

  lock_code_entry #(
    .CODE_LEN  (LEN),
    .DEBOUNCE  (DB),
    .MAX_TRIES (MAXT),
    .RESET_CODE(RCODE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .num      (num),
    .lock_cmd (lock_cmd),
    .prog     (prog),
    .unlocked (unlocked),
    .alarm    (alarm),
    .entered  (entered),
    .disp     (disp)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int  hist[$];
  bit  armed, pend;
  int  pdig;
  bit  m_open, m_prog, m_alarm, m_check, m_valid;
  int  digs[$];
  int  code[LEN];
  int  fails;
  int  d;
  bit  same, match;

  always @(posedge clk) begin
    if (rst) begin
      hist.delete();
      armed = 0; pend = 0; pdig = 0;
      m_open = 0; m_prog = 0; m_alarm = 0; m_check = 0;
      digs.delete();
      for (int i = 0; i < LEN; i++) code[i] = int'((RCODE >> (4 * (LEN - 1 - i))) & 16'hF);
      fails = 0;
      m_valid = 1;
    end else begin
      // lock behaviour, driven by the press detected on the previous edge
      if (m_alarm) begin
      end else if (m_check) begin
        match = (digs.size() == LEN);
        for (int i = 0; i < LEN && match; i++) if (digs[i] != code[i]) match = 0;
        digs.delete();
        m_check = 0;
        if (match) begin
          m_open = 1; fails = 0;
        end else begin
          if (fails < MAXT) fails++;
          if (fails >= MAXT) m_alarm = 1;
        end
      end else if (m_prog) begin
        if (lock_cmd) begin
          m_prog = 0; m_open = 0; digs.delete();
        end else if (pend) begin
          digs.push_back(pdig);
          if (digs.size() == LEN) begin
            for (int i = 0; i < LEN; i++) code[i] = digs[i];
            digs.delete();
            m_prog = 0;
          end
        end
      end else if (m_open) begin
        if (lock_cmd) m_open = 0;
        else if (pend && prog) begin
          m_prog = 1; digs.push_back(pdig);
        end
      end else begin
        if (lock_cmd) digs.delete();
        else if (pend) begin
          digs.push_back(pdig);
          if (digs.size() == LEN) m_check = 1;
        end
      end
      // press detection: last DB samples identical
      d = (num >= 4'd1 && num <= 4'd9) ? int'(num) : 0;
      hist.push_back(d);
      if (hist.size() > DB) void'(hist.pop_front());
      pend = 0;
      if (hist.size() == DB) begin
        same = 1;
        foreach (hist[k]) if (hist[k] != d) same = 0;
        if (same) begin
          if (d != 0 && armed) begin
            pend = 1; pdig = d; armed = 0;
          end else if (d == 0) begin
            armed = 1;
          end
        end
      end
    end
  end

  function automatic logic [9:0] model_out();
    logic [3:0] dsp;
    if (m_alarm)              dsp = 4'hE;
    else if (m_prog)          dsp = 4'hF;
    else if (m_open)          dsp = 4'h0;
    else if (digs.size() > 0) dsp = 4'(digs[$]);
    else                      dsp = 4'hC;
    return {m_open, m_alarm, 4'(digs.size()), dsp};
  endfunction

  always @(negedge clk) begin
    if (m_valid) chk("cycle", {22'd0, unlocked, alarm, entered, disp}, {22'd0, model_out()});
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic key(input int dg, input int hold, input int rel);
    num = 4'(dg);
    tick(hold);
    num = 4'd0;
    tick(rel);
  endtask

  task automatic enter(input int c0, input int c1, input int c2, input int c3);
    key(c0, 6, 6); key(c1, 6, 6); key(c2, 6, 6); key(c3, 6, 6);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(DB + 2);
  endtask

  task automatic pulse_lock();
    lock_cmd = 1'b1;
    tick(1);
    lock_cmd = 1'b0;
    tick(1);
  endtask

  int r;

  initial begin
    tick(2);
    chk("reset_state", {unlocked, alarm, entered, disp}, {1'b0, 1'b0, 4'd0, 4'hC});
    rst = 1'b0;
    tick(DB + 2);

    // 1: correct combination
    key(1, 6, 6); chk("t1_entered1", entered, 1);
    key(2, 6, 6); chk("t1_entered2", entered, 2);
    key(3, 6, 6); chk("t1_entered3", entered, 3);
    key(4, 6, 6);
    chk("t1_open", {unlocked, alarm, entered, disp}, {1'b1, 1'b0, 4'd0, 4'h0});

    // 2: three wrong tries raise the alarm
    pulse_lock();
    chk("t2_relocked", unlocked, 0);
    enter(1, 2, 3, 5); chk("t2_try1", {unlocked, alarm}, 2'b00);
    enter(1, 2, 3, 5); chk("t2_try2", {unlocked, alarm}, 2'b00);
    enter(1, 2, 3, 5); chk("t2_alarm", {alarm, disp}, {1'b1, 4'hE});
    enter(1, 2, 3, 4); pulse_lock();
    chk("t2_alarm_sticky", {unlocked, alarm, entered, disp}, {1'b0, 1'b1, 4'd0, 4'hE});
    do_reset();
    chk("t2_rst_clears", {alarm, disp}, {1'b0, 4'hC});

    // 3: debounce boundaries
    num = 4'd3; tick(3); num = 4'd0; tick(6);
    chk("t3_short_pulse", entered, 0);
    num = 4'd3; tick(20);
    chk("t3_held_once", entered, 1);
    num = 4'd5; tick(10);
    chk("t3_no_rollover", {entered, disp}, {4'd1, 4'd3});
    num = 4'd0; tick(6);
    do_reset();

    // 4: program a new code
    enter(1, 2, 3, 4);
    prog = 1'b1;
    enter(9, 8, 7, 6);
    prog = 1'b0;
    chk("t4_prog_done", {unlocked, entered, disp}, {1'b1, 4'd0, 4'h0});
    pulse_lock();
    chk("t4_locked", unlocked, 0);
    enter(1, 2, 3, 4);
    chk("t4_old_code_rejected", {unlocked, alarm}, 2'b00);
    enter(9, 8, 7, 6);
    chk("t4_new_code_opens", unlocked, 1);

    // 5: abort programming keeps the old code
    do_reset();
    enter(1, 2, 3, 4);
    prog = 1'b1;
    key(5, 6, 6); key(6, 6, 6);
    prog = 1'b0;
    chk("t5_programming", {unlocked, entered, disp}, {1'b1, 4'd2, 4'hF});
    pulse_lock();
    chk("t5_aborted", {unlocked, entered, disp}, {1'b0, 4'd0, 4'hC});
    enter(1, 2, 3, 4);
    chk("t5_old_code_kept", unlocked, 1);

    // 6: reset mid-entry
    do_reset();
    key(1, 6, 6); key(2, 6, 6);
    chk("t6_partial", {entered, disp}, {4'd2, 4'd2});
    rst = 1'b1; tick(1); rst = 1'b0;
    chk("t6_rst_mid", {entered, disp}, {4'd0, 4'hC});
    tick(DB + 2);
    enter(1, 2, 3, 4);
    chk("t6_unlock", unlocked, 1);

    // random traffic against the model
    do_reset();
    repeat (400) begin
      r = $urandom_range(0, 19);
      if (r == 0) pulse_lock();
      else if (r == 1) prog = 1'($urandom_range(0, 1));
      else if (r == 2 || (m_alarm && r < 6)) do_reset();
      else if (r == 3) begin
        num = 4'($urandom_range(1, 9)); tick($urandom_range(1, 6));
        num = 4'($urandom_range(1, 15)); tick($urandom_range(1, 6));
        num = 4'd0; tick($urandom_range(1, 8));
      end else if (r == 4) key($urandom_range(10, 15), $urandom_range(1, 8), $urandom_range(1, 8));
      else if (r < 12) key($urandom_range(1, 4), $urandom_range(1, 8), $urandom_range(1, 8));
      else key($urandom_range(1, 9), $urandom_range(1, 8), $urandom_range(1, 8));
    end
    tick(10);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
